fetch_unit: RTL and testbench

//  IF stage and IF/ID register of the 5-stage MIPS pipeline, with a handshaked instruction-memory port.

---
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// IF stage plus IF/ID register: one outstanding instruction fetch over a valid/ready
// memory port, a single-entry response buffer for a stalled Decode, and redirect handling.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        RedirectValid,
   input  logic [31:0] RedirectPC,
   output logic        ImemReqValid,
   output logic [31:0] ImemReqAddr,
   input  logic        ImemReqReady,
   input  logic        ImemRespValid,
   input  logic [31:0] ImemRespData,
   output logic [31:0] PCOutF,
   output logic [31:0] PCPlus4D,
   output logic [31:0] InstructionD,
   output logic        ValidD
);

   typedef enum logic [1:0] {
      ST_REQ,
      ST_WAIT,
      ST_HOLD,
      ST_DROP
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;

   logic        d_can_load;
   logic        load_en;
   logic [31:0] load_data;
   logic [31:0] pc_plus4;

   assign pc_plus4     = pc_q + 32'd4;
   // A bubble in IF/ID may always be overwritten, even under a stall.
   assign d_can_load   = ~StallD | ~valid_q | FlushD;
   assign ImemReqValid = (state_q == ST_REQ) & ~RedirectValid & ~Reset;
   assign ImemReqAddr  = pc_q;
   assign PCOutF       = pc_q;
   assign PCPlus4D     = pc4_q;
   assign InstructionD = instr_q;
   assign ValidD       = valid_q;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      buf_d     = buf_q;
      instr_d   = instr_q;
      pc4_d     = pc4_q;
      valid_d   = valid_q;
      load_en   = 1'b0;
      load_data = ImemRespData;

      case (state_q)
         ST_REQ: begin
            if (ImemReqValid && ImemReqReady) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (RedirectValid) begin
               state_d = ImemRespValid ? ST_REQ : ST_DROP;
            end else if (ImemRespValid) begin
               if (d_can_load) begin
                  load_en = 1'b1;
                  state_d = ST_REQ;
               end else begin
                  buf_d   = ImemRespData;
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (RedirectValid) begin
               state_d = ST_REQ;
            end else if (d_can_load) begin
               load_en   = 1'b1;
               load_data = buf_q;
               state_d   = ST_REQ;
            end
         end
         ST_DROP: begin
            // The stale response is the only one in flight; once it lands we are free to refetch.
            if (ImemRespValid) begin
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_REQ;
      endcase

      if (load_en) begin
         instr_d = load_data;
         pc4_d   = pc_plus4;
         valid_d = 1'b1;
         pc_d    = pc_plus4;
      end else if (FlushD) begin
         instr_d = 32'h0;
         valid_d = 1'b0;
      end

      if (RedirectValid) begin
         pc_d = RedirectPC & 32'hFFFF_FFFC;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_REQ;
         pc_q    <= RESET_PC;
         buf_q   <= 32'h0;
         instr_q <= 32'h0;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         buf_q   <= buf_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each step drives one cycle of inputs, checks the request
// port before the edge and the PC / IF-ID outputs just after it.
module tb_fetch_unit;

   logic        Clk;
   logic        Reset;
   logic        StallD;
   logic        FlushD;
   logic        RedirectValid;
   logic [31:0] RedirectPC;
   logic        ImemReqValid;
   logic [31:0] ImemReqAddr;
   logic        ImemReqReady;
   logic        ImemRespValid;
   logic [31:0] ImemRespData;
   logic [31:0] PCOutF;
   logic [31:0] PCPlus4D;
   logic [31:0] InstructionD;
   logic        ValidD;

   int tests_run = 0;
   int tests_failed = 0;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .StallD       (StallD),
      .FlushD       (FlushD),
      .RedirectValid(RedirectValid),
      .RedirectPC   (RedirectPC),
      .ImemReqValid (ImemReqValid),
      .ImemReqAddr  (ImemReqAddr),
      .ImemReqReady (ImemReqReady),
      .ImemRespValid(ImemRespValid),
      .ImemRespData (ImemRespData),
      .PCOutF       (PCOutF),
      .PCPlus4D     (PCPlus4D),
      .InstructionD (InstructionD),
      .ValidD       (ValidD)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      string       name;
      logic        rst, stall, flush, rv;
      logic [31:0] rpc;
      logic        rdy, rsp_v;
      logic [31:0] rsp_d;
      logic        e_req_v;
      logic [31:0] e_addr, e_pc, e_pc4, e_instr;
      logic        e_valid;
   } vec_t;

   function automatic vec_t mk(input string name,
                               input logic rst, input logic stall, input logic flush,
                               input logic rv, input logic [31:0] rpc, input logic rdy,
                               input logic rsp_v, input logic [31:0] rsp_d,
                               input logic e_req_v, input logic [31:0] e_addr,
                               input logic [31:0] e_pc, input logic [31:0] e_pc4,
                               input logic [31:0] e_instr, input logic e_valid);
      vec_t v;
      v.name = name; v.rst = rst; v.stall = stall; v.flush = flush; v.rv = rv; v.rpc = rpc;
      v.rdy = rdy; v.rsp_v = rsp_v; v.rsp_d = rsp_d; v.e_req_v = e_req_v; v.e_addr = e_addr;
      v.e_pc = e_pc; v.e_pc4 = e_pc4; v.e_instr = e_instr; v.e_valid = e_valid;
      return v;
   endfunction

   task automatic chk(input string name, input string field, input logic [31:0] act,
                      input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s.%s: got %08h expected %08h", name, field, act, exp);
      end
   endtask

   // Called at #1 after a rising edge; returns at #1 after the next one.
   task automatic apply(input vec_t v);
      Reset = v.rst; StallD = v.stall; FlushD = v.flush; RedirectValid = v.rv;
      RedirectPC = v.rpc; ImemReqReady = v.rdy; ImemRespValid = v.rsp_v; ImemRespData = v.rsp_d;
      #1;
      chk(v.name, "req_valid", {31'b0, ImemReqValid}, {31'b0, v.e_req_v});
      chk(v.name, "req_addr", ImemReqAddr, v.e_addr);
      @(posedge Clk);
      #1;
      chk(v.name, "pc", PCOutF, v.e_pc);
      chk(v.name, "pc4", PCPlus4D, v.e_pc4);
      chk(v.name, "instr", InstructionD, v.e_instr);
      chk(v.name, "valid", {31'b0, ValidD}, {31'b0, v.e_valid});
      $display("[TB] %-12s pc=%08h pc4=%08h instr=%08h v=%0b", v.name, PCOutF, PCPlus4D,
               InstructionD, ValidD);
   endtask

   vec_t tbl[10];

   initial begin
      Reset = 1'b1; StallD = 1'b0; FlushD = 1'b0; RedirectValid = 1'b0; RedirectPC = 32'h0;
      ImemReqReady = 1'b0; ImemRespValid = 1'b0; ImemRespData = 32'h0;
      @(posedge Clk);
      #1;

      // name rst stall flush rv rpc rdy rspv rspd | req_v addr pc pc4 instr valid
      tbl[0] = mk("reset",     1,0,0,0,32'h0,0,0,32'h0,        0,32'h0, 32'h0, 32'h0, 32'h0,        0);
      tbl[1] = mk("req0",      0,0,0,0,32'h0,1,0,32'h0,        1,32'h0, 32'h0, 32'h0, 32'h0,        0);
      tbl[2] = mk("resp0",     0,0,0,0,32'h0,1,1,32'h20080005, 0,32'h0, 32'h4, 32'h4, 32'h20080005, 1);
      tbl[3] = mk("req4",      0,0,0,0,32'h0,1,0,32'h0,        1,32'h4, 32'h4, 32'h4, 32'h20080005, 1);
      tbl[4] = mk("resp4",     0,0,0,0,32'h0,1,1,32'h20090003, 0,32'h4, 32'h8, 32'h8, 32'h20090003, 1);
      tbl[5] = mk("flush",     0,0,1,0,32'h0,0,0,32'h0,        1,32'h8, 32'h8, 32'h8, 32'h0,        0);
      tbl[6] = mk("req8",      0,0,0,0,32'h0,1,0,32'h0,        1,32'h8, 32'h8, 32'h8, 32'h0,        0);
      tbl[7] = mk("resp8",     0,0,0,0,32'h0,1,1,32'h8C0A0000, 0,32'h8, 32'hC, 32'hC, 32'h8C0A0000, 1);
      tbl[8] = mk("reqC",      0,0,0,0,32'h0,1,0,32'h0,        1,32'hC, 32'hC, 32'hC, 32'h8C0A0000, 1);
      tbl[9] = mk("flush_ld",  0,1,1,0,32'h0,0,1,32'hAC0B0004, 0,32'hC, 32'h10,32'h10,32'hAC0B0004, 1);
      for (int i = 0; i < 10; i++) apply(tbl[i]);

      // Stalled Decode: response parked in the buffer, released when the stall drops.
      apply(mk("hold_req",  0,1,0,0,32'h0,1,0,32'h0,        1,32'h10,32'h10,32'h10,32'hAC0B0004,1));
      apply(mk("hold_rsp",  0,1,0,0,32'h0,0,1,32'h01095020, 0,32'h10,32'h10,32'h10,32'hAC0B0004,1));
      apply(mk("hold_wait", 0,1,0,0,32'h0,1,0,32'h0,        0,32'h10,32'h10,32'h10,32'hAC0B0004,1));
      apply(mk("hold_rel",  0,0,0,0,32'h0,0,0,32'h0,        0,32'h10,32'h14,32'h14,32'h01095020,1));
      apply(mk("req14",     0,0,0,0,32'h0,0,0,32'h0,        1,32'h14,32'h14,32'h14,32'h01095020,1));

      // Redirect while waiting: late response discarded, refetch from the target.
      apply(mk("req14_fl",  0,0,1,0,32'h0,1,0,32'h0,        1,32'h14,32'h14,32'h14,32'h0,0));
      apply(mk("redir_w",   0,0,0,1,32'h43,0,0,32'h0,       0,32'h14,32'h40,32'h14,32'h0,0));
      apply(mk("drop_wait", 0,0,0,0,32'h0,1,0,32'h0,        0,32'h40,32'h40,32'h14,32'h0,0));
      apply(mk("drop_rsp",  0,0,0,0,32'h0,1,1,32'hDEADBEEF, 0,32'h40,32'h40,32'h14,32'h0,0));
      apply(mk("req40",     0,0,0,0,32'h0,0,0,32'h0,        1,32'h40,32'h40,32'h14,32'h0,0));
      apply(mk("redir_req", 0,0,0,1,32'h100,1,0,32'h0,      0,32'h40,32'h100,32'h14,32'h0,0));

      // Back-pressure and PC wrap at the top of the address space.
      apply(mk("redir_top", 0,0,0,1,32'hFFFFFFFF,0,0,32'h0, 0,32'h100,32'hFFFFFFFC,32'h14,32'h0,0));
      for (int i = 0; i < 3; i++)
         apply(mk("busy",   0,0,0,0,32'h0,0,0,32'h0,        1,32'hFFFFFFFC,32'hFFFFFFFC,32'h14,32'h0,0));
      apply(mk("req_top",   0,0,0,0,32'h0,1,0,32'h0,        1,32'hFFFFFFFC,32'hFFFFFFFC,32'h14,32'h0,0));
      apply(mk("rsp_top",   0,0,0,0,32'h0,0,1,32'h03E00008, 0,32'hFFFFFFFC,32'h0,32'h0,32'h03E00008,1));
      apply(mk("req_wrap",  0,0,0,0,32'h0,1,0,32'h0,        1,32'h0,32'h0,32'h0,32'h03E00008,1));
      apply(mk("rsp_wrap",  0,0,0,0,32'h0,0,1,32'h22222222, 0,32'h0,32'h4,32'h4,32'h22222222,1));

      // Reset out of HOLD, then a late response must be ignored.
      apply(mk("req4b",     0,1,0,0,32'h0,1,0,32'h0,        1,32'h4,32'h4,32'h4,32'h22222222,1));
      apply(mk("hold4b",    0,1,0,0,32'h0,0,1,32'h33333333, 0,32'h4,32'h4,32'h4,32'h22222222,1));
      apply(mk("rst_hold",  1,1,0,0,32'h0,1,0,32'h0,        0,32'h4,32'h0,32'h0,32'h0,0));
      apply(mk("late_h",    0,0,0,0,32'h0,0,1,32'h44444444, 1,32'h0,32'h0,32'h0,32'h0,0));

      // Reset out of DROP, then a late response must be ignored.
      apply(mk("req0b",     0,0,0,0,32'h0,1,0,32'h0,        1,32'h0,32'h0,32'h0,32'h0,0));
      apply(mk("redir_d",   0,0,0,1,32'h200,0,0,32'h0,      0,32'h0,32'h200,32'h0,32'h0,0));
      apply(mk("rst_drop",  1,0,0,0,32'h0,1,0,32'h0,        0,32'h200,32'h0,32'h0,32'h0,0));
      apply(mk("late_d",    0,0,0,0,32'h0,0,1,32'h55555555, 1,32'h0,32'h0,32'h0,32'h0,0));
      apply(mk("idle",      0,0,0,0,32'h0,0,0,32'h0,        1,32'h0,32'h0,32'h0,32'h0,0));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
